// File: rtl/audio_dac_tx.sv
// audio_dac_tx: WM8731 slave-mode DAC transmitter generating BCLK/DACLRCK and left-justified PCM on DACDAT.
// Optional feature macro AUDIO_DAC_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt[15:0] output.
module audio_dac_tx #(
    parameter int unsigned CLK_FRE    = 50_000_000,
    parameter int unsigned BCLK_DIV   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              frame_tick,
    output logic              underrun
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_W;
    localparam int unsigned BW         = $clog2(FRAME_BITS);
    localparam int unsigned DW         = $clog2(BCLK_DIV);
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW         = 2 * DATA_W;

    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT_START = BW'(SLOT_W);
    localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    // Reject parameter sets the datapath cannot represent.
    if (BCLK_DIV < 2 || SLOT_W < DATA_W || DATA_W == 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLK_FRE == 0) begin : g_param_check
        $error("audio_dac_tx: unsupported parameter set");
    end

    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_nxt;
    logic [BW-1:0]     slot_bit;
    logic [DATA_W-1:0] last_l;
    logic [DATA_W-1:0] last_r;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] cur_sample;
    logic [DATA_W-1:0] cur_shift;
    logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              div_tc;
    logic              fall;
    logic              load;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              lrck_nxt;
    logic              dat_nxt;

    // Next-state for divider, frame counter, FIFO occupancy and the serial bit.
    always_comb begin
        div_tc     = (div_cnt == DIV_LAST);
        fall       = div_tc && AUD_BCLK;
        load       = fall && (bit_cnt == BIT_LAST);
        fifo_empty = (count == '0);
        push       = sample_valid && sample_ready;
        pop        = load && !fifo_empty;
        bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end

        // A load either takes the FIFO head or repeats the held frame.
        hold_l = last_l;
        hold_r = last_r;
        if (pop) begin
            {hold_l, hold_r} = fifo_mem[rd_ptr];
        end

        lrck_nxt   = (bit_nxt >= SLOT_START);
        slot_bit   = lrck_nxt ? (bit_nxt - SLOT_START) : bit_nxt;
        cur_sample = lrck_nxt ? hold_r : hold_l;
        // Shifting past DATA_W leaves zeros, which is the slot padding.
        cur_shift  = cur_sample << slot_bit;
        dat_nxt    = cur_shift[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            AUD_BCLK     <= 1'b0;
            bit_cnt      <= BIT_LAST;
            AUD_DACLRCK  <= 1'b0;
            AUD_DACDAT   <= 1'b0;
            frame_tick   <= 1'b0;
            underrun     <= 1'b0;
            last_l       <= '0;
            last_r       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_ready <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
            if (div_tc) begin
                AUD_BCLK <= ~AUD_BCLK;
            end
            frame_tick <= load;
            underrun   <= load && fifo_empty;
            if (fall) begin
                bit_cnt     <= bit_nxt;
                AUD_DACLRCK <= lrck_nxt;
                AUD_DACDAT  <= dat_nxt;
            end
            if (load) begin
                last_l <= hold_l;
                last_r <= hold_r;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count        <= count_nxt;
            sample_ready <= (count_nxt != FULL_CNT);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= {sample_l, sample_r};
        end
    end

`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (load && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// Scoreboard bench for audio_dac_tx: accepted frames are queued and compared against the deserialised DACDAT stream.
// Define AUDIO_DAC_TX_UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_audio_dac_tx;

    localparam int unsigned BCLK_DIV   = 2;
    localparam int unsigned SLOT_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAME_CLK  = 2 * BCLK_DIV * 2 * SLOT_W;
    localparam int unsigned WAIT_MAX   = 2 * FRAME_CLK + 16;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] sample_l = '0;
    logic [DATA_W-1:0] sample_r = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              AUD_BCLK;
    logic              AUD_DACLRCK;
    logic              AUD_DACDAT;
    logic              frame_tick;
    logic              underrun;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    audio_dac_tx #(
        .CLK_FRE   (50_000_000),
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_W    (SLOT_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .frame_tick  (frame_tick),
        .underrun    (underrun)
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    frame_t            exp_q[$];
    frame_t            staged;
    logic              staged_v   = 1'b0;
    frame_t            hold       = '0;
    frame_t            exp_cur    = '0;
    int unsigned       cyc        = 0;
    logic              collecting = 1'b0;
    int                nbits      = 0;
    logic [DATA_W-1:0] got_l      = '0;
    logic [DATA_W-1:0] got_r      = '0;
    logic              prev_bclk  = 1'b0;
    logic              rise_v     = 1'b0;
    logic              tick_v     = 1'b0;
    int unsigned       last_rise  = 0;
    int unsigned       last_tick  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: loads pop the scoreboard, BCLK rises deserialise the frame.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            staged_v   = 1'b0;
            hold       = '0;
            collecting = 1'b0;
            rise_v     = 1'b0;
            tick_v     = 1'b0;
            prev_bclk  = 1'b0;
        end else begin
            if (frame_tick) begin
                if (collecting) check_eq("frame_bits", nbits, 2 * SLOT_W);
                check_eq("underrun", {31'd0, underrun}, {31'd0, exp_q.size() == 0});
                if (exp_q.size() != 0) hold = exp_q.pop_front();
                exp_cur = hold;
                if (tick_v) check_eq("frame_period", cyc - last_tick, FRAME_CLK);
                last_tick  = cyc;
                tick_v     = 1'b1;
                collecting = 1'b1;
                nbits      = 0;
            end
            if (underrun) check_eq("underrun_with_tick", {31'd0, frame_tick}, 32'd1);
            if (staged_v) exp_q.push_back(staged);
            staged_v = sample_valid && sample_ready;
            staged   = {sample_l, sample_r};
            if (AUD_BCLK && !prev_bclk) begin
                if (rise_v) check_eq("bclk_period", cyc - last_rise, 2 * BCLK_DIV);
                last_rise = cyc;
                rise_v    = 1'b1;
                if (collecting) begin
                    check_eq("lrck", {31'd0, AUD_DACLRCK}, {31'd0, nbits >= int'(SLOT_W)});
                    if (!AUD_DACLRCK) got_l = {got_l[DATA_W-2:0], AUD_DACDAT};
                    else              got_r = {got_r[DATA_W-2:0], AUD_DACDAT};
                    nbits++;
                    if (nbits == int'(2 * SLOT_W)) begin
                        check_eq("left", {16'd0, got_l}, {16'd0, exp_cur.l});
                        check_eq("right", {16'd0, got_r}, {16'd0, exp_cur.r});
                        collecting = 1'b0;
                    end
                end
            end
            prev_bclk = AUD_BCLK;
        end
    end

    task automatic reset_dut();
        int n;
        @(posedge clk);
        #1 rst = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_outputs", {26'd0, sample_ready, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT,
                 frame_tick, underrun}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!frame_tick && n < 40);
        check_eq("first_fall_cycles", n, 4);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            int b = 0;
            do begin
                @(negedge clk);
                b++;
            end while (!frame_tick && b < int'(WAIT_MAX));
            if (!frame_tick) check_eq("frame_timeout", {31'd0, frame_tick}, 32'd1);
        end
    endtask

    task automatic push_one(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input logic keep, output logic waited);
        int b = 0;
        @(posedge clk);
        #1;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        do begin
            @(negedge clk);
            b++;
        end while (!sample_ready && b < int'(WAIT_MAX));
        if (!sample_ready) check_eq("push_timeout", {31'd0, sample_ready}, 32'd1);
        waited = (b > 1);
        // Ready can only reopen on the load edge that pops the full FIFO.
        if (waited) check_eq("push_after_pop", {31'd0, frame_tick}, 32'd1);
        if (!keep) begin
            @(posedge clk);
            #1 sample_valid = 1'b0;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic w;
        int   b;

        // Idle after reset: repeated zero frames, each flagged as underrun.
        reset_dut();
        wait_frames(3);

        // Single frame followed by repeats of it.
        push_one(16'hA5C3, 16'h0001, 1'b0, w);
        wait_frames(4);

        // Back-to-back stream that overflows the FIFO and waits on pops.
        wait_frames(1);
        for (int i = 0; i < 6; i++) begin
            logic [DATA_W-1:0] l;
            l = DATA_W'(16'h1111 * (i + 1)) ^ 16'h0F0F;
            push_one(l, ~l, (i < 5), w);
            check_eq("push_waited", {31'd0, w}, {31'd0, i >= int'(FIFO_DEPTH)});
        end
        wait_frames(8);

        // Reset in the middle of a right slot.
        push_one(16'h1234, 16'h8765, 1'b0, w);
        wait_frames(1);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!AUD_DACLRCK && b < int'(WAIT_MAX));
        repeat (3) @(negedge clk);
        reset_dut();
        wait_frames(1);
        push_one(16'hBEEF, 16'hCAFE, 1'b0, w);
        wait_frames(3);

`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
        reset_dut();
        wait_frames(4);
        check_eq("underrun_cnt_5", {16'd0, underrun_cnt}, 32'd5);
        @(posedge clk);
        #1 force dut.underrun_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_cnt;
        wait_frames(3);
        check_eq("underrun_cnt_sat", {16'd0, underrun_cnt}, 32'h0000FFFF);
`endif

        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
